// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the ARM pipeline stage registers and pipe_hazard_ctrl.
// The master side (the controller) samples pipeline status and drives the clear/freeze controls.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic [3:0]       exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_r_en;
  logic [3:0]       mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             if_freeze;
  logic             if_flush;
  logic             id_clr;
  logic             back_freeze;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    output if_freeze, if_flush, id_clr, back_freeze, mem_err,
           stall_cnt, flush_cnt
  );

  modport slave (
    output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
    input  if_freeze, if_flush, id_clr, back_freeze, mem_err,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flushes, data-memory wait/timeout, perf counters.
// Optional macro FORWARDING_EN reduces RAW detection to the EXE load-use case.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.master  hz
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               raw_hit;
  logic               if_freeze, if_flush, id_clr, back_freeze;

`ifdef FORWARDING_EN
  logic unused_mem_fwd;
  assign unused_mem_fwd = ^{hz.mem_dest, hz.mem_wb_en};
  assign raw_hit = hz.exe_mem_r_en && hz.exe_wb_en &&
                   ((hz.exe_dest == hz.src1) || (hz.two_src && (hz.exe_dest == hz.src2)));
`else
  logic unused_load_flag;
  assign unused_load_flag = hz.exe_mem_r_en;
  assign raw_hit = (hz.exe_wb_en && (hz.exe_dest == hz.src1)) ||
                   (hz.two_src && hz.exe_wb_en && (hz.exe_dest == hz.src2)) ||
                   (hz.mem_wb_en && (hz.mem_dest == hz.src1)) ||
                   (hz.two_src && hz.mem_wb_en && (hz.mem_dest == hz.src2));
`endif

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    if_freeze   = 1'b0;
    if_flush    = 1'b0;
    id_clr      = 1'b0;
    back_freeze = 1'b0;
    case (state_q)
      RUN: begin
        if (hz.mem_req && !hz.mem_ready) begin
          if_freeze   = 1'b1;
          back_freeze = 1'b1;
          state_d     = MEM_WAIT;
          wait_d      = WAIT_W'(1);
        end else if (hz.branch_taken) begin
          if_flush = 1'b1;
          id_clr   = 1'b1;
          flush_d  = (&flush_q) ? flush_q : flush_q + CNT_W'(1);
        end else if (raw_hit) begin
          if_freeze = 1'b1;
          id_clr    = 1'b1;
          stall_d   = (&stall_q) ? stall_q : stall_q + CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if_freeze   = 1'b1;
        back_freeze = 1'b1;
        if (hz.mem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (wait_d == WAIT_W'(MEM_TIMEOUT)) state_d = ERR;
        end
      end
      ERR: begin
        if_freeze   = 1'b1;
        back_freeze = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Controls are combinational from live inputs, so mask them while reset is held.
  assign hz.if_freeze   = if_freeze   & rst;
  assign hz.if_flush    = if_flush    & rst;
  assign hz.id_clr      = id_clr      & rst;
  assign hz.back_freeze = back_freeze & rst;
  assign hz.mem_err     = (state_q == ERR);
  assign hz.stall_cnt   = stall_q;
  assign hz.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl: a short-timeout/narrow-counter instance (a)
// and a default-timeout instance (b) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(3))  ifa ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) ifb ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .hz  (ifa.master)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(64), .CNT_W(16)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .hz  (ifb.master)
  );

  assign ifb.src1         = ifa.src1;
  assign ifb.src2         = ifa.src2;
  assign ifb.two_src      = ifa.two_src;
  assign ifb.exe_dest     = ifa.exe_dest;
  assign ifb.exe_wb_en    = ifa.exe_wb_en;
  assign ifb.exe_mem_r_en = ifa.exe_mem_r_en;
  assign ifb.mem_dest     = ifa.mem_dest;
  assign ifb.mem_wb_en    = ifa.mem_wb_en;
  assign ifb.branch_taken = ifa.branch_taken;
  assign ifb.mem_req      = ifa.mem_req;
  assign ifb.mem_ready    = ifa.mem_ready;

  // {if_freeze, if_flush, id_clr, back_freeze}
  logic [3:0] ctrl_a, ctrl_b;
  assign ctrl_a = {ifa.if_freeze, ifa.if_flush, ifa.id_clr, ifa.back_freeze};
  assign ctrl_b = {ifb.if_freeze, ifb.if_flush, ifb.id_clr, ifb.back_freeze};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.src1 = 4'd0; ifa.src2 = 4'd0; ifa.two_src = 1'b0;
    ifa.exe_dest = 4'd9; ifa.exe_wb_en = 1'b0; ifa.exe_mem_r_en = 1'b0;
    ifa.mem_dest = 4'd10; ifa.mem_wb_en = 1'b0;
    ifa.branch_taken = 1'b0; ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
  endtask

  task automatic bump_stall();
    exp_stall = (exp_stall == 7) ? 7 : exp_stall + 1;
  endtask

  initial begin
    idle();
    #3;
    check_eq("rst_ctrl", ctrl_a, 4'b0000);
    check_eq("rst_err", ifa.mem_err, 1'b0);
    check_eq("rst_stall", ifa.stall_cnt, 0);
    check_eq("rst_flush", ifa.flush_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    @(negedge clk);
    check_eq("idle_ctrl", ctrl_a, 4'b0000);
    tick();

    // Branch flush
    ifa.branch_taken = 1'b1;
    @(negedge clk);
    check_eq("br_ctrl", ctrl_a, 4'b0110);
    check_eq("br_cnt_before", ifa.flush_cnt, 0);
    tick();
    exp_flush++;
    idle();
    @(negedge clk);
    check_eq("br_cnt_after", ifa.flush_cnt, exp_flush);
    check_eq("br_release", ctrl_a, 4'b0000);
    tick();

    // MEM-stage RAW on src1
    ifa.src1 = 4'd3; ifa.mem_wb_en = 1'b1; ifa.mem_dest = 4'd3;
    @(negedge clk);
`ifdef FORWARDING_EN
    check_eq("memraw_ctrl", ctrl_a, 4'b0000);
`else
    check_eq("memraw_ctrl", ctrl_a, 4'b1010);
    bump_stall();
`endif
    tick();
    idle();
    @(negedge clk);
    check_eq("memraw_cnt", ifa.stall_cnt, exp_stall);
    tick();

    // Load-use on src2
    ifa.exe_mem_r_en = 1'b1; ifa.exe_wb_en = 1'b1; ifa.exe_dest = 4'd5;
    ifa.two_src = 1'b1; ifa.src2 = 4'd5;
    @(negedge clk);
    check_eq("lu_src2_ctrl", ctrl_a, 4'b1010);
    bump_stall();
    tick();
    ifa.two_src = 1'b0;
    @(negedge clk);
    check_eq("lu_nosrc2_ctrl", ctrl_a, 4'b0000);
    check_eq("lu_cnt", ifa.stall_cnt, exp_stall);
    tick();

    // Register 15 compared like any other
    ifa.exe_dest = 4'd15; ifa.src1 = 4'd15;
    @(negedge clk);
    check_eq("pc_ctrl", ctrl_a, 4'b1010);
    bump_stall();
    tick();

    // Branch outranks hazard (hazard inputs still present)
    ifa.branch_taken = 1'b1;
    @(negedge clk);
    check_eq("br_over_raw", ctrl_a, 4'b0110);
    tick();
    exp_flush++;
    idle();
    @(negedge clk);
    check_eq("br_over_raw_stall", ifa.stall_cnt, exp_stall);
    check_eq("br_over_raw_flush", ifa.flush_cnt, exp_flush);
    tick();

    // Single-cycle access: no freeze, branch evaluated
    ifa.mem_req = 1'b1; ifa.mem_ready = 1'b1; ifa.branch_taken = 1'b1;
    @(negedge clk);
    check_eq("mem1_ctrl", ctrl_a, 4'b0110);
    tick();
    exp_flush++;
    idle();

    // Memory wait of 3 cycles then ready, branch held throughout
    ifa.mem_req = 1'b1; ifa.mem_ready = 1'b0; ifa.branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ifa.mem_ready = 1'b1;
      @(negedge clk);
      check_eq($sformatf("wait_ctrl%0d", i), ctrl_a, 4'b1001);
      tick();
    end
    ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
    @(negedge clk);
    check_eq("wait_flush_cnt", ifa.flush_cnt, exp_flush);
    check_eq("wait_release_ctrl", ctrl_a, 4'b0110);
    tick();
    exp_flush++;
    idle();
    @(negedge clk);
    check_eq("wait_release_cnt", ifa.flush_cnt, exp_flush);
    tick();

    // Stall counter saturation (CNT_W=3)
    ifa.exe_mem_r_en = 1'b1; ifa.exe_wb_en = 1'b1; ifa.exe_dest = 4'd7; ifa.src1 = 4'd7;
    for (int i = 0; i < 8; i++) begin
      tick();
      bump_stall();
    end
    idle();
    @(negedge clk);
    check_eq("stall_sat", ifa.stall_cnt, exp_stall);
    check_eq("stall_sat_max", ifa.stall_cnt, 7);
    tick();

    // Timeout: 4 wait cycles then ERR on instance a
    ifa.mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("to_ctrl%0d", i), ctrl_a, 4'b1001);
      check_eq($sformatf("to_err_early%0d", i), ifa.mem_err, 1'b0);
      tick();
    end
    @(negedge clk);
    check_eq("to_err", ifa.mem_err, 1'b1);
    check_eq("to_err_ctrl", ctrl_a, 4'b1001);
    ifa.mem_req = 1'b0; ifa.mem_ready = 1'b1; ifa.branch_taken = 1'b1;
    tick();
    @(negedge clk);
    check_eq("err_sticky", ifa.mem_err, 1'b1);
    check_eq("err_ignores_ready", ctrl_a, 4'b1001);
    check_eq("b_left_wait", ctrl_b, 4'b0110);
    tick();

    // Instance b into MEM_WAIT with wait counter 5, then async reset mid-cycle
    idle();
    ifa.mem_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    @(negedge clk);
    check_eq("b_wait_ctrl", ctrl_b, 4'b1001);
    check_eq("b_wait_noerr", ifb.mem_err, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_ctrl_a", ctrl_a, 4'b0000);
    check_eq("arst_ctrl_b", ctrl_b, 4'b0000);
    check_eq("arst_err_a", ifa.mem_err, 1'b0);
    check_eq("arst_stall_a", ifa.stall_cnt, 0);
    check_eq("arst_flush_a", ifa.flush_cnt, 0);
    check_eq("arst_flush_b", ifb.flush_cnt, 0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_eq("post_rst_ctrl_b", ctrl_b, 4'b0000);
    check_eq("post_rst_err_a", ifa.mem_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control initiator that drives the clear/freeze controls consumed by the IF/ID and ID/EX stage registers of the ARM pipeline. It detects RAW hazards, branch-taken flushes and data-memory wait states. It holds a small wait/timeout state machine and saturating performance counters.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before the error state (minimum 2)
CNT_W, 16, width of performance counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous reset, active-low (asserted at 0)
src1  in  4  Rn index of instruction in ID
src2  in  4  Rm/Rd index of instruction in ID
two_src  in  1  ID instruction reads src2 (register operand or store)
exe_dest  in  4  Dest_out of ID/EX register
exe_wb_en  in  1  WB_EN_out of ID/EX register
exe_mem_r_en  in  1  MEM_R_EN_out of ID/EX register (load in EXE)
mem_dest  in  4  destination in EXE/MEM register
mem_wb_en  in  1  WB_EN in EXE/MEM register
branch_taken  in  1  B_out of ID/EX register (branch resolving in EXE)
mem_req  in  1  MEM stage issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
if_freeze  out  1  hold PC and IF/ID register
if_flush  out  1  clear IF/ID register
id_clr  out  1  clr of ID/EX register
back_freeze  out  1  hold EXE/MEM and MEM/WB registers
mem_err  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with if_freeze=1 caused by a RAW hazard
flush_cnt  out  CNT_W  number of branch flushes

Behaviour:
- States: RUN, MEM_WAIT, ERR. State and counters are registered. Control outputs are combinational from state and inputs, so they take effect at the same edge (zero latency).
- Reset (rst=0, async): state=RUN, wait counter=0, mem_err=0, stall_cnt=0, flush_cnt=0. All control outputs are 0 while in reset.
- raw_hit = (exe_wb_en && exe_dest==src1) || (two_src && exe_wb_en && exe_dest==src2) || (mem_wb_en && mem_dest==src1) || (two_src && mem_wb_en && mem_dest==src2).
- RUN priority, highest first:
  1. mem_req && !mem_ready: assert all four controls, except that if_flush=0 and id_clr=0 (freeze only). Go to MEM_WAIT with wait counter=1.
  2. branch_taken: if_flush=1, id_clr=1, if_freeze=0. flush_cnt+1.
  3. raw_hit: if_freeze=1, id_clr=1 (bubble inserted). stall_cnt+1.
  4. Otherwise all controls are 0.
- MEM_WAIT:
  - if_freeze=1, back_freeze=1; id_clr=0 and if_flush=0, so branch/hazard inputs are ignored and re-evaluated after release.
  - mem_ready=1: freezes still asserted this cycle; next state RUN; wait counter cleared.
  - Otherwise the wait counter increments. When it reaches MEM_TIMEOUT, go to ERR.
- ERR: mem_err=1, if_freeze=1, back_freeze=1, held until reset. mem_ready is ignored.
- Counters saturate at all-ones; they do not wrap.
- mem_req and mem_ready both 1 in RUN: this is a single-cycle access, so no freeze occurs and branch/hazard are evaluated normally.
- Register index 15 (PC) is compared like any other index.

Optional Feature:
FORWARDING_EN:
- Defined: forwarding paths exist, so raw_hit is reduced to a load-use check only: exe_mem_r_en && exe_wb_en && (exe_dest==src1 || (two_src && exe_dest==src2)). MEM-stage matches never stall.
- Undefined: the full raw_hit above applies.

Test Plan:
- Reset: rst=0 mid-MEM_WAIT with counter=5 -> state RUN, all outputs 0, counters 0 immediately (asynchronous).
- Branch: branch_taken=1 for 1 cycle in RUN -> if_flush=1, id_clr=1 that cycle; flush_cnt 0->1.
- Hazard, FORWARDING_EN undefined: src1=3, mem_wb_en=1, mem_dest=3 -> if_freeze=1, id_clr=1; stall_cnt increments. Same stimulus with FORWARDING_EN defined -> no stall.
- Load-use: exe_mem_r_en=1, exe_wb_en=1, exe_dest=5, two_src=1, src2=5 -> stall in both builds. With two_src=0 -> no stall.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1; branch_taken=1 throughout -> back_freeze=1 for 4 cycles; id_clr=0 throughout the wait; first cycle back in RUN gives if_flush=1.
- Timeout: MEM_TIMEOUT=4, mem_ready stuck at 0 -> mem_err=1 after 4 wait cycles; freezes remain asserted until rst=0.
